// File: rtl/cpu_mem_pkg.sv
// ---------------------------------------------------------------------------
// cpu_mem_pkg
// Shared constants and types for the data memory responder slice.
//   WORD_W  : data word width (32)
//   CNT_W   : width of the wait-state down-counter (4, covers 0..15)
//   state_t : responder FSM state (IDLE / WAIT / RESP)
// Optional feature macro used by the slice: DMEM_ERR_CHECK_EN
// ---------------------------------------------------------------------------
package cpu_mem_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage : cpu_mem_pkg

// File: rtl/data_mem_responder_if.sv
// ---------------------------------------------------------------------------
// data_mem_responder_if
// CPU <-> data memory request/response bundle.
//   req_valid_i / req_ready_o : request handshake
//   req_we_i                  : 1 = store, 0 = load
//   req_addr_i                : byte address (word index = addr[31:2])
//   req_wdata_i               : store data
//   rsp_valid_o / rsp_ready_i : response handshake
//   rsp_rdata_o               : load data (0 for stores and errors)
//   rsp_err_o                 : request rejected
// Suffixes are from the responder's point of view.
//   slave  : used by the responder
//   master : used by the CPU side
// ---------------------------------------------------------------------------
interface data_mem_responder_if;
    import cpu_mem_pkg::*;

    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_we_i;
    logic [WORD_W-1:0] req_addr_i;
    logic [WORD_W-1:0] req_wdata_i;
    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [WORD_W-1:0] rsp_rdata_o;
    logic              rsp_err_o;

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

endinterface : data_mem_responder_if

// File: rtl/dmem_array.sv
// ---------------------------------------------------------------------------
// dmem_array
// Word storage with one synchronous write port and one registered read
// port. No reset: contents survive responder resets.
//   clk_i            : clock
//   we_i / waddr_i / wdata_i : write port
//   re_i / raddr_i   : read port (data appears after the enabling edge)
//   rdata_o          : read data, held until the next enabled read
// ---------------------------------------------------------------------------
module dmem_array
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : dmem_array

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
// Single-outstanding data memory responder with a fixed number of wait
// states between request accept and response.
//   Parameters: DEPTH (words, power of two 4..1024), WAIT_CYCLES (0..15)
//   clk_i : clock (rising edge)
//   rst_i : asynchronous active-low reset
//   bus   : data_mem_responder_if.slave request/response bundle
// Optional feature: define DMEM_ERR_CHECK_EN to reject misaligned or
// out-of-range addresses (rsp_err_o=1, no write, load data 0). Without it
// addr[1:0] is ignored and the word index wraps modulo DEPTH.
// ---------------------------------------------------------------------------
module data_mem_responder
    import cpu_mem_pkg::*;
#(
    parameter int DEPTH       = 128,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    data_mem_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              req_ready_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic              rsp_load_q;
    logic              we_q;
    logic [WORD_W-1:0] addr_q;
    logic [WORD_W-1:0] wdata_q;

    logic              accept;
    logic              enter_resp;
    logic              op_we_d;
    logic [WORD_W-1:0] op_addr_d;
    logic [WORD_W-1:0] op_wdata_d;
    logic              op_err_d;
    logic              mem_we;
    logic              mem_re;
    logic [WORD_W-1:0] mem_rdata;

    assign accept = (state_q == IDLE) && req_ready_q && bus.req_valid_i;

    // With zero wait states the accept edge is also the edge entering RESP,
    // so the operation is taken straight from the bus instead of the latches.
    generate
        if (WAIT_CYCLES == 0) begin : g_no_wait
            assign enter_resp = accept;
            assign op_we_d    = bus.req_we_i;
            assign op_addr_d  = bus.req_addr_i;
            assign op_wdata_d = bus.req_wdata_i;
        end else begin : g_wait
            assign enter_resp = (state_q == WAIT) && (cnt_q == '0);
            assign op_we_d    = we_q;
            assign op_addr_d  = addr_q;
            assign op_wdata_d = wdata_q;
        end
    endgenerate

`ifdef DMEM_ERR_CHECK_EN
    assign op_err_d = (op_addr_d[1:0] != 2'b00) ||
                      (op_addr_d[WORD_W-1:2] >= 30'(DEPTH));
`else
    assign op_err_d = 1'b0;
`endif

    // Address bits outside the word index only matter for the error check.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{op_addr_d[1:0], op_addr_d[WORD_W-1:AW+2]};

    // Memory side effects happen only on the edge that enters RESP.
    assign mem_we = enter_resp &&  op_we_d && !op_err_d;
    assign mem_re = enter_resp && !op_we_d && !op_err_d;

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (mem_we),
        .waddr_i (op_addr_d[AW+1:2]),
        .wdata_i (op_wdata_d),
        .re_i    (mem_re),
        .raddr_i (op_addr_d[AW+1:2]),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_load_q  <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Ready is registered so it stays low for one cycle
                    // after reset release.
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        req_ready_q <= 1'b0;
                        we_q        <= bus.req_we_i;
                        addr_q      <= bus.req_addr_i;
                        wdata_q     <= bus.req_wdata_i;
                        if (WAIT_CYCLES == 0) begin
                            state_q     <= RESP;
                            rsp_valid_q <= 1'b1;
                            rsp_err_q   <= op_err_d;
                            rsp_load_q  <= !op_we_d && !op_err_d;
                        end else begin
                            state_q <= WAIT;
                            cnt_q   <= CNT_W'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt_q == '0) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= op_err_d;
                        rsp_load_q  <= !op_we_d && !op_err_d;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready_i) begin
                        state_q     <= IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_err_q   <= 1'b0;
                        rsp_load_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    req_ready_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_load_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready_o = req_ready_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_err_o   = rsp_err_q;
    // The array read register holds its value until the next load, so the
    // gated data stays stable for the whole RESP state.
    assign bus.rsp_rdata_o = rsp_load_q ? mem_rdata : '0;

endmodule : data_mem_responder

// File: tb/tb_data_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_data_mem_responder
// Directed bench for data_mem_responder: one instance with WAIT_CYCLES=2
// (bus_a) and one with WAIT_CYCLES=0 (bus_b), sharing clock and reset.
// Honours DMEM_ERR_CHECK_EN for the configuration-dependent steps.
// ---------------------------------------------------------------------------
module tb_data_mem_responder;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    data_mem_responder_if bus_a ();
    data_mem_responder_if bus_b ();

    data_mem_responder #(.DEPTH(128), .WAIT_CYCLES(2)) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus_a)
    );

    data_mem_responder #(.DEPTH(128), .WAIT_CYCLES(0)) dut0 (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request on bus_a. Call at posedge+1. Expects latency WAIT_CYCLES+1
    // (=3). If hold>0 the response is stalled for hold cycles, checking it
    // stays stable, with a spurious store pulse to 0x10 in the second cycle.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rdata,
                          input logic exp_err, input int hold);
        int lat;
        int w;
        w = 0;
        while (bus_a.req_ready_o !== 1'b1 && w < 20) begin
            @(posedge clk); #1; w++;
        end
        check({tag, "_ready"}, {31'd0, bus_a.req_ready_o}, 32'd1);
        bus_a.req_valid_i = 1'b1;
        bus_a.req_we_i    = we;
        bus_a.req_addr_i  = addr;
        bus_a.req_wdata_i = wdata;
        lat = 0;
        do begin
            @(posedge clk); #1;
            bus_a.req_valid_i = 1'b0;
            lat++;
        end while (bus_a.rsp_valid_o !== 1'b1 && lat < 20);
        check({tag, "_lat"},   32'(lat), 32'd3);
        check({tag, "_rdata"}, bus_a.rsp_rdata_o, exp_rdata);
        check({tag, "_err"},   {31'd0, bus_a.rsp_err_o}, {31'd0, exp_err});
        for (int i = 0; i < hold; i++) begin
            if (i == 1) begin
                bus_a.req_valid_i = 1'b1;
                bus_a.req_we_i    = 1'b1;
                bus_a.req_addr_i  = 32'h10;
                bus_a.req_wdata_i = 32'h12345678;
            end
            @(posedge clk); #1;
            bus_a.req_valid_i = 1'b0;
            check({tag, "_hold_valid"}, {31'd0, bus_a.rsp_valid_o}, 32'd1);
            check({tag, "_hold_rdata"}, bus_a.rsp_rdata_o, exp_rdata);
            check({tag, "_hold_ready"}, {31'd0, bus_a.req_ready_o}, 32'd0);
        end
        bus_a.rsp_ready_i = 1'b1;
        @(posedge clk); #1;
        bus_a.rsp_ready_i = 1'b0;
        check({tag, "_done_valid"}, {31'd0, bus_a.rsp_valid_o}, 32'd0);
        check({tag, "_done_ready"}, {31'd0, bus_a.req_ready_o}, 32'd1);
        $display("txn %s we=%0b addr=%h wdata=%h lat=%0d rdata=%h err=%0b",
                 tag, we, addr, wdata, lat, exp_rdata, exp_err);
    endtask

    // One request on bus_b (WAIT_CYCLES=0, rsp_ready held 1, req_valid held 1).
    task automatic do_req_b(input string tag, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [31:0] exp_rdata);
        bus_b.req_valid_i = 1'b1;
        bus_b.req_we_i    = we;
        bus_b.req_addr_i  = addr;
        bus_b.req_wdata_i = wdata;
        check({tag, "_ready"}, {31'd0, bus_b.req_ready_o}, 32'd1);
        @(posedge clk); #1;
        check({tag, "_valid1"}, {31'd0, bus_b.rsp_valid_o}, 32'd1);
        check({tag, "_rdata"},  bus_b.rsp_rdata_o, exp_rdata);
        check({tag, "_busy"},   {31'd0, bus_b.req_ready_o}, 32'd0);
        @(posedge clk); #1;
        check({tag, "_valid0"}, {31'd0, bus_b.rsp_valid_o}, 32'd0);
        $display("txn %s we=%0b addr=%h wdata=%h rdata=%h", tag, we, addr, wdata, exp_rdata);
    endtask

    initial begin
        bus_a.req_valid_i = 1'b0; bus_a.req_we_i = 1'b0;
        bus_a.req_addr_i  = '0;   bus_a.req_wdata_i = '0;
        bus_a.rsp_ready_i = 1'b0;
        bus_b.req_valid_i = 1'b0; bus_b.req_we_i = 1'b0;
        bus_b.req_addr_i  = '0;   bus_b.req_wdata_i = '0;
        bus_b.rsp_ready_i = 1'b1;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_ready", {31'd0, bus_a.req_ready_o}, 32'd0);
        check("rst_valid", {31'd0, bus_a.rsp_valid_o}, 32'd0);
        check("rst_rdata", bus_a.rsp_rdata_o, 32'd0);
        check("rst_err",   {31'd0, bus_a.rsp_err_o}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rel_ready0", {31'd0, bus_a.req_ready_o}, 32'd0);
        @(posedge clk); #1;
        check("rel_ready1", {31'd0, bus_a.req_ready_o}, 32'd1);

        // Store then load
        do_req("st10", 1'b1, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
        do_req("ld10", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);

        // Stalled response with an ignored request pulse, then confirm 0x10 unchanged
        do_req("st14", 1'b1, 32'h14, 32'h0BADF00D, 32'h0, 1'b0, 0);
        do_req("ld14_stall", 1'b0, 32'h14, 32'h0, 32'h0BADF00D, 1'b0, 5);
        do_req("ld10_after", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);

`ifdef DMEM_ERR_CHECK_EN
        // Misaligned store rejected, word unchanged; out-of-range load rejected
        do_req("st13_err", 1'b1, 32'h13, 32'h55555555, 32'h0, 1'b1, 0);
        do_req("ld10_keep", 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
        do_req("ld200_err", 1'b0, 32'h200, 32'h0, 32'h0, 1'b1, 0);
`else
        // Index 128 wraps to 0; low address bits ignored
        do_req("st200", 1'b1, 32'h200, 32'h1, 32'h0, 1'b0, 0);
        do_req("ld0",   1'b0, 32'h0,   32'h0, 32'h1, 1'b0, 0);
        do_req("ld203", 1'b0, 32'h203, 32'h0, 32'h1, 1'b0, 0);
`endif

        // Reset in the middle of a store's WAIT discards it
        do_req("st20", 1'b1, 32'h20, 32'h11111111, 32'h0, 1'b0, 0);
        bus_a.req_valid_i = 1'b1; bus_a.req_we_i = 1'b1;
        bus_a.req_addr_i  = 32'h20; bus_a.req_wdata_i = 32'hAAAA5555;
        @(posedge clk); #1;
        bus_a.req_valid_i = 1'b0;
        check("mid_busy", {31'd0, bus_a.req_ready_o}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready", {31'd0, bus_a.req_ready_o}, 32'd0);
        check("mid_rst_valid", {31'd0, bus_a.rsp_valid_o}, 32'd0);
        check("mid_rst_rdata", bus_a.rsp_rdata_o, 32'd0);
        check("mid_rst_err",   {31'd0, bus_a.rsp_err_o}, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("mid_rel_ready", {31'd0, bus_a.req_ready_o}, 32'd1);
        do_req("ld20_old", 1'b0, 32'h20, 32'h0, 32'h11111111, 1'b0, 0);

        // Zero wait states, back-to-back with req_valid held high
        do_req_b("b_st8", 1'b1, 32'h8, 32'hCAFE0001, 32'h0);
        do_req_b("b_ld8", 1'b0, 32'h8, 32'h0, 32'hCAFE0001);
        do_req_b("b_stC", 1'b1, 32'hC, 32'hCAFE0002, 32'h0);
        do_req_b("b_ldC", 1'b0, 32'hC, 32'h0, 32'hCAFE0002);
        bus_b.req_valid_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_data_mem_responder

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH, default 128, shall set the number of 32-bit words stored (power of two, 4..1024).
REQ-002 Parameter WAIT_CYCLES, default 2, shall set the wait states between request accept and response (0..15).
REQ-003 clk_i  input  1  shall be the single clock; all state shall update on its rising edge.
REQ-004 rst_i  input  1  shall be the reset: asynchronous, active-low.
REQ-005 req_valid_i  input  1  shall flag a CPU request present.
REQ-006 req_ready_o  output  1  shall flag that the responder can accept a request this cycle.
REQ-007 req_we_i  input  1  shall select the operation: 1 = store, 0 = load.
REQ-008 req_addr_i  input  32  shall be the byte address; the word index is addr[31:2].
REQ-009 req_wdata_i  input  32  shall be the store data.
REQ-010 rsp_valid_o  output  1  shall flag a response present.
REQ-011 rsp_ready_i  input  1  shall flag that the CPU accepts the response.
REQ-012 rsp_rdata_o  output  32  shall be the load data; it shall be 0 for stores and errors.
REQ-013 rsp_err_o  output  1  shall flag that the request was rejected.

Function
REQ-014 The FSM shall have exactly three states: IDLE, WAIT, RESP.
REQ-015 In IDLE, req_ready_o shall be 1; in WAIT and RESP, req_ready_o shall be 0.
REQ-016 Accept shall occur on an edge where req_valid_i=1 in IDLE; addr, we and wdata shall be latched on that edge.
REQ-017 On accept, the FSM shall move to RESP if WAIT_CYCLES=0, otherwise to WAIT with the counter loaded to WAIT_CYCLES-1.
REQ-018 WAIT shall decrement the counter each cycle and move to RESP on the edge where the counter is 0.
REQ-019 rsp_valid_o shall rise exactly WAIT_CYCLES+1 cycles after the accept edge and shall be 1 only in RESP.
REQ-020 A store shall commit to the array on the edge entering RESP, never earlier.
REQ-021 A load shall capture the array word on the edge entering RESP; a load issued after a store shall return the stored value.
REQ-022 rsp_rdata_o and rsp_err_o shall be held stable while rsp_valid_o=1 and rsp_ready_i=0.
REQ-023 From RESP, the FSM shall return to IDLE on the edge where rsp_ready_i=1.
REQ-024 A new request shall not be accepted in the same cycle a response completes; the minimum request spacing is WAIT_CYCLES+2 cycles.
REQ-025 req_valid_i asserted outside IDLE shall be ignored; no latching and no side effects shall occur.

Reset
REQ-026 Asserting rst_i low shall immediately force the FSM to IDLE, the counter to 0, req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0 and rsp_err_o=0.
REQ-027 req_ready_o shall go to 1 on the first clock edge after rst_i is released.
REQ-028 Reset while in WAIT shall discard the pending store, leaving the array unmodified.
REQ-029 Reset shall not clear the array contents.

Configuration
REQ-030 With macro DMEM_ERR_CHECK_EN defined, rsp_err_o shall be set when addr[1:0]!=0 or the word index is >= DEPTH.
REQ-031 With DMEM_ERR_CHECK_EN defined, an erroring store shall not write, and an erroring load shall return 0.
REQ-032 Without DMEM_ERR_CHECK_EN, addr[1:0] shall be ignored, the word index shall wrap modulo DEPTH, and rsp_err_o shall be constant 0.

Structure
REQ-033 Shared package cpu_mem_pkg shall hold WORD_W=32, the state enum type (IDLE/WAIT/RESP) and the WAIT counter width constant (4).
REQ-034 Storage shall be a sub-module dmem_array: one write port and one read port, synchronous on clk_i, no reset.

Verification
REQ-035 Scenario: WAIT_CYCLES=2; store 0xDEADBEEF to addr 0x10, then load addr 0x10 -> rsp_valid_o at accept+3 for each; load returns rdata 0xDEADBEEF, err 0.
REQ-036 Scenario: hold rsp_ready_i=0 for 5 cycles in RESP -> rsp_valid_o and rdata stable throughout; req_ready_o=0; a req_valid_i pulse during this time is ignored.
REQ-037 Scenario (DMEM_ERR_CHECK_EN): store to addr 0x13, then load 0x10 -> first response err=1; load returns the previous value; word unchanged.
REQ-038 Scenario (no macro): DEPTH=128; store 0x1 to addr 0x200 (index 128) -> load addr 0x0 returns 0x1, err 0.
REQ-039 Scenario: assert reset mid-WAIT of a store of 0xAAAA5555 to addr 0x20 -> outputs go to 0 immediately; a later load of 0x20 returns the old value.
REQ-040 Scenario: WAIT_CYCLES=0; back-to-back requests with rsp_ready_i held 1 -> responses at accept+1; accepts spaced every 2 cycles.
